// File: rtl/gsplat_tile_dispatch_pkg.sv
// Shared constants and payload types for the gsplat tile dispatcher.
package gsplat_tile_dispatch_pkg;

    localparam int unsigned ADDR_W       = 29;
    localparam int unsigned FIELD_W      = 16;
    localparam int unsigned DATA_W       = 64;
    localparam int unsigned BURST_W      = 8;
    localparam int unsigned HDR_QWORDS   = 2;
    localparam int unsigned SPLAT_QWORDS = 4;

    // Header qword0 field offsets
    localparam int unsigned PX_LSB       = 0;
    localparam int unsigned PY_LSB       = 16;
    localparam int unsigned CNT_LSB      = 32;

    // Dispatch FSM encoding
    localparam int unsigned ST_W         = 3;
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_HDR_REQ    = 3'd1;
    localparam logic [2:0] ST_HDR_WAIT   = 3'd2;
    localparam logic [2:0] ST_HOLD       = 3'd3;
    localparam logic [2:0] ST_DRAIN      = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;

    typedef struct packed {
        logic [FIELD_W-1:0] splat_count;
        logic [FIELD_W-1:0] py;
        logic [FIELD_W-1:0] px;
    } tile_hdr_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        tile_hdr_t         hdr;
    } tile_dispatch_t;

    // Address of the descriptor that follows one with the given splat count
    function automatic logic [ADDR_W-1:0] next_desc_addr(input logic [ADDR_W-1:0]  addr,
                                                         input logic [FIELD_W-1:0] cnt);
        return addr + ADDR_W'(HDR_QWORDS) + ADDR_W'(cnt) * ADDR_W'(SPLAT_QWORDS);
    endfunction

endpackage

// File: rtl/gsplat_tile_dispatch_if.sv
// Header-read port and core dispatch bus of the tile dispatcher.
interface gsplat_tile_dispatch_if
    import gsplat_tile_dispatch_pkg::*;
#(
    parameter int unsigned NUM_CORES = 2
);
    logic [ADDR_W-1:0]    rd_addr;
    logic [BURST_W-1:0]   rd_burstcnt;
    logic                 rd_req;
    logic                 rd_ack;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_data_valid;
    logic [NUM_CORES-1:0] core_start;
    logic [ADDR_W-1:0]    core_tile_addr;
    logic [FIELD_W-1:0]   core_tile_px;
    logic [FIELD_W-1:0]   core_tile_py;
    logic [FIELD_W-1:0]   core_splat_count;
    logic [NUM_CORES-1:0] core_done;

    modport master (
        output rd_addr, rd_burstcnt, rd_req,
        input  rd_ack, rd_data, rd_data_valid,
        output core_start, core_tile_addr, core_tile_px, core_tile_py, core_splat_count,
        input  core_done
    );

    modport slave (
        input  rd_addr, rd_burstcnt, rd_req,
        output rd_ack, rd_data, rd_data_valid,
        input  core_start, core_tile_addr, core_tile_px, core_tile_py, core_splat_count,
        output core_done
    );
endinterface

// File: rtl/gsplat_tile_dispatch.sv
// Frame coordinator: walks the tile descriptor list, fetches each header and
// hands tiles to the lowest-index free core, then signals frame completion.
module gsplat_tile_dispatch
    import gsplat_tile_dispatch_pkg::*;
#(
    parameter int unsigned NUM_CORES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic [ADDR_W-1:0]      list_addr,
    input  logic [FIELD_W-1:0]     tile_count,
    output logic                   busy,
    output logic                   frame_done,
    gsplat_tile_dispatch_if.master bus
);

    logic [ST_W-1:0]      state_q,      state_d;
    logic                 busy_q,       busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 rd_req_q,     rd_req_d;
    logic [ADDR_W-1:0]    rd_addr_q,    rd_addr_d;
    logic [NUM_CORES-1:0] core_start_q, core_start_d;
    tile_dispatch_t       disp_q,       disp_d;
    logic [NUM_CORES-1:0] occ_q,        occ_d;
    logic [ADDR_W-1:0]    cur_addr_q,   cur_addr_d;
    logic [FIELD_W-1:0]   tiles_left_q, tiles_left_d;
    tile_hdr_t            hdr_q,        hdr_d;
    logic                 beat_q,       beat_d;
    logic [NUM_CORES-1:0] grant;

    // Lowest set bit of v as a one-hot vector (zero when v is zero)
    function automatic logic [NUM_CORES-1:0] lowest_one(input logic [NUM_CORES-1:0] v);
        logic [NUM_CORES-1:0] r;
        r = '0;
        for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
            if (v[i]) r = NUM_CORES'(1) << i;
        end
        return r;
    endfunction

    assign busy                 = busy_q;
    assign frame_done           = frame_done_q;
    assign bus.rd_req           = rd_req_q;
    assign bus.rd_addr          = rd_addr_q;
    assign bus.rd_burstcnt      = BURST_W'(HDR_QWORDS);
    assign bus.core_start       = core_start_q;
    assign bus.core_tile_addr   = disp_q.addr;
    assign bus.core_tile_px     = disp_q.hdr.px;
    assign bus.core_tile_py     = disp_q.hdr.py;
    assign bus.core_splat_count = disp_q.hdr.splat_count;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            core_start_q <= '0;
            disp_q       <= '0;
            occ_q        <= '0;
            cur_addr_q   <= '0;
            tiles_left_q <= '0;
            hdr_q        <= '0;
            beat_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            core_start_q <= core_start_d;
            disp_q       <= disp_d;
            occ_q        <= occ_d;
            cur_addr_q   <= cur_addr_d;
            tiles_left_q <= tiles_left_d;
            hdr_q        <= hdr_d;
            beat_q       <= beat_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        rd_req_d     = rd_req_q;
        rd_addr_d    = rd_addr_q;
        core_start_d = '0;
        disp_d       = disp_q;
        occ_d        = occ_q & ~bus.core_done;
        cur_addr_d   = cur_addr_q;
        tiles_left_d = tiles_left_q;
        hdr_d        = hdr_q;
        beat_d       = beat_q;
        // A core finishing this cycle is already eligible for the next tile
        grant        = lowest_one(~occ_q | bus.core_done);

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    cur_addr_d   = list_addr;
                    tiles_left_d = tile_count;
                    busy_d       = 1'b1;
                    state_d      = (tile_count == '0) ? ST_DRAIN : ST_HDR_REQ;
                end
            end
            ST_HDR_REQ: begin
                if (!rd_req_q) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = cur_addr_q;
                end else if (bus.rd_ack) begin
                    rd_req_d = 1'b0;
                    beat_d   = 1'b0;
                    state_d  = ST_HDR_WAIT;
                end
            end
            ST_HDR_WAIT: begin
                if (bus.rd_data_valid) begin
                    if (!beat_q) begin
                        hdr_d.px          = bus.rd_data[PX_LSB  +: FIELD_W];
                        hdr_d.py          = bus.rd_data[PY_LSB  +: FIELD_W];
                        hdr_d.splat_count = bus.rd_data[CNT_LSB +: FIELD_W];
                        beat_d            = 1'b1;
                    end else begin
                        beat_d  = 1'b0;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (grant != '0) begin
                    core_start_d = grant;
                    disp_d.addr  = cur_addr_q;
                    disp_d.hdr   = hdr_q;
                    occ_d        = occ_d | grant;
                    cur_addr_d   = next_desc_addr(cur_addr_q, hdr_q.splat_count);
                    tiles_left_d = tiles_left_q - FIELD_W'(1);
                    state_d      = (tiles_left_q == FIELD_W'(1)) ? ST_DRAIN : ST_HDR_REQ;
                end
            end
            ST_DRAIN: begin
                if (occ_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gsplat_tile_dispatch.sv
// Directed bench for the gsplat tile dispatcher with a hand-driven memory/core model.
module tb_gsplat_tile_dispatch;

    logic        clk;
    logic        reset_n;
    logic        frame_start;
    logic [28:0] list_addr;
    logic [15:0] tile_count;
    logic        busy;
    logic        frame_done;

    int checks;
    int failures;

    gsplat_tile_dispatch_if #(.NUM_CORES(2)) bus ();

    gsplat_tile_dispatch #(.NUM_CORES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .list_addr   (list_addr),
        .tile_count  (tile_count),
        .busy        (busy),
        .frame_done  (frame_done),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] hdr(input logic [15:0] px, input logic [15:0] py,
                                        input logic [15:0] cnt);
        return {16'hA5A5, cnt, py, px};
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.rd_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_frame_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Accept one header request and return qword0 followed by a junk qword1
    task automatic serve_hdr(input logic [63:0] q0, output logic [28:0] addr, output bit ok);
        wait_req(ok);
        addr = bus.rd_addr;
        if (!ok) return;
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack        = 1'b0;
        bus.rd_data_valid = 1'b1;
        bus.rd_data       = q0;
        @(negedge clk);
        bus.rd_data = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
    endtask

    task automatic start_frame(input logic [28:0] a, input logic [15:0] n);
        list_addr   = a;
        tile_count  = n;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        checks++; if (bus.rd_req !== 1'b0) begin failures++; $display("FAIL reset_rd_req got=%b want=0", bus.rd_req); end
        checks++; if (bus.core_start !== 2'b00) begin failures++; $display("FAIL reset_core_start got=%b want=00", bus.core_start); end
        checks++; if (bus.rd_burstcnt !== 8'd2) begin failures++; $display("FAIL reset_burstcnt got=%0d want=2", bus.rd_burstcnt); end
        checks++; if (bus.rd_addr !== 29'h0) begin failures++; $display("FAIL reset_rd_addr got=%h want=0", bus.rd_addr); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_tiles();
        bit saw_req;
        start_frame(29'h40, 16'd0);
        saw_req = bus.rd_req;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy got=%b want=1", busy); end
        @(negedge clk);
        saw_req |= bus.rd_req;
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL zero_done_early got=%b want=0", frame_done); end
        @(negedge clk);
        saw_req |= bus.rd_req;
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL zero_done_cycle2 got=%b want=1", frame_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_after got=%b want=0", busy); end
        checks++; if (saw_req !== 1'b0) begin failures++; $display("FAIL zero_no_rd_req got=%b want=0", saw_req); end
        @(negedge clk);
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%b want=0", frame_done); end
    endtask

    task automatic test_three_tiles();
        logic [28:0] a;
        bit ok;
        start_frame(29'h100, 16'd3);
        checks++; if (bus.rd_req !== 1'b0) begin failures++; $display("FAIL three_req_lat1 got=%b want=0", bus.rd_req); end
        @(negedge clk);
        checks++; if (bus.rd_req !== 1'b1) begin failures++; $display("FAIL three_req_lat2 got=%b want=1", bus.rd_req); end
        serve_hdr(hdr(16'h0010, 16'h0020, 16'd5), a, ok);
        checks++; if (!ok || a !== 29'h100) begin failures++; $display("FAIL three_addr0 got=%h ok=%0d want=100", a, ok); end
        @(negedge clk);
        checks++; if (bus.core_start !== 2'b01) begin failures++; $display("FAIL three_start0 got=%b want=01", bus.core_start); end
        checks++; if (bus.core_tile_addr !== 29'h100 || bus.core_tile_px !== 16'h10 || bus.core_tile_py !== 16'h20 || bus.core_splat_count !== 16'd5)
            begin failures++; $display("FAIL three_bus0 got=%h/%h/%h/%0d want=100/10/20/5", bus.core_tile_addr, bus.core_tile_px, bus.core_tile_py, bus.core_splat_count); end
        serve_hdr(hdr(16'h0030, 16'h0040, 16'd0), a, ok);
        checks++; if (!ok || a !== 29'h116) begin failures++; $display("FAIL three_addr1 got=%h ok=%0d want=116", a, ok); end
        @(negedge clk);
        checks++; if (bus.core_start !== 2'b10) begin failures++; $display("FAIL three_start1 got=%b want=10", bus.core_start); end
        serve_hdr(hdr(16'h0050, 16'h0060, 16'd7), a, ok);
        checks++; if (!ok || a !== 29'h118) begin failures++; $display("FAIL three_addr2 got=%h ok=%0d want=118", a, ok); end
        @(negedge clk);
        checks++; if (bus.core_start !== 2'b00) begin failures++; $display("FAIL three_hold got=%b want=00", bus.core_start); end
        checks++; if (bus.core_tile_addr !== 29'h116) begin failures++; $display("FAIL three_bus_hold got=%h want=116", bus.core_tile_addr); end
        bus.core_done = 2'b01;
        @(negedge clk);
        bus.core_done = 2'b00;
        checks++; if (bus.core_start !== 2'b01) begin failures++; $display("FAIL three_start2 got=%b want=01", bus.core_start); end
        checks++; if (bus.core_tile_addr !== 29'h118 || bus.core_splat_count !== 16'd7 || bus.core_tile_px !== 16'h50)
            begin failures++; $display("FAIL three_bus2 got=%h/%0d/%h want=118/7/50", bus.core_tile_addr, bus.core_splat_count, bus.core_tile_px); end
        @(negedge clk);
        checks++; if (bus.rd_req !== 1'b0) begin failures++; $display("FAIL three_no_more_req got=%b want=0", bus.rd_req); end
        bus.core_done = 2'b11;
        @(negedge clk);
        bus.core_done = 2'b00;
        checks++; if (frame_done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL three_done_c1 got=%b/%b want=0/1", frame_done, busy); end
        @(negedge clk);
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL three_done_c2 got=%b want=0", frame_done); end
        @(negedge clk);
        checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL three_done_c3 got=%b/%b want=1/0", frame_done, busy); end
        @(negedge clk);
    endtask

    task automatic test_ack_stall();
        bit ok;
        int extra;
        start_frame(29'h200, 16'd1);
        wait_req(ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_req_timeout got=0 want=1"); end
        for (int i = 0; i < 10; i++) begin
            frame_start = (i == 3);
            list_addr   = (i == 3) ? 29'h7777 : 29'h200;
            @(negedge clk);
            checks++; if (bus.rd_req !== 1'b1 || bus.rd_addr !== 29'h200)
                begin failures++; $display("FAIL stall_stable%0d got=%b/%h want=1/200", i, bus.rd_req, bus.rd_addr); end
        end
        frame_start = 1'b0;
        bus.rd_ack  = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        checks++; if (bus.rd_req !== 1'b0) begin failures++; $display("FAIL stall_req_drop got=%b want=0", bus.rd_req); end
        bus.rd_data_valid = 1'b1;
        bus.rd_data       = hdr(16'h1, 16'h2, 16'd9);
        @(negedge clk);
        bus.rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        @(negedge clk);
        checks++; if (bus.core_start !== 2'b01 || bus.core_splat_count !== 16'd9)
            begin failures++; $display("FAIL stall_dispatch got=%b/%0d want=01/9", bus.core_start, bus.core_splat_count); end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.rd_req) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL stall_single_req got=%0d want=0", extra); end
        bus.core_done = 2'b01;
        @(negedge clk);
        bus.core_done = 2'b00;
        wait_frame_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_frame_done got=0 want=1"); end
        @(negedge clk);
    endtask

    task automatic test_done_priority();
        logic [28:0] a;
        bit ok;
        start_frame(29'h300, 16'd4);
        serve_hdr(hdr(16'd0, 16'd0, 16'd0), a, ok);
        @(negedge clk);
        checks++; if (bus.core_start !== 2'b01) begin failures++; $display("FAIL prio_start0 got=%b want=01", bus.core_start); end
        serve_hdr(hdr(16'd1, 16'd0, 16'd0), a, ok);
        @(negedge clk);
        checks++; if (bus.core_start !== 2'b10) begin failures++; $display("FAIL prio_start1 got=%b want=10", bus.core_start); end
        serve_hdr(hdr(16'd2, 16'd0, 16'd0), a, ok);
        checks++; if (!ok || a !== 29'h304) begin failures++; $display("FAIL prio_addr2 got=%h ok=%0d want=304", a, ok); end
        @(negedge clk);
        checks++; if (bus.core_start !== 2'b00) begin failures++; $display("FAIL prio_hold got=%b want=00", bus.core_start); end
        bus.core_done = 2'b10;
        @(negedge clk);
        bus.core_done = 2'b00;
        checks++; if (bus.core_start !== 2'b10 || bus.core_tile_px !== 16'd2)
            begin failures++; $display("FAIL prio_core1 got=%b/%0d want=10/2", bus.core_start, bus.core_tile_px); end
        serve_hdr(hdr(16'd3, 16'd0, 16'd0), a, ok);
        checks++; if (!ok || a !== 29'h306) begin failures++; $display("FAIL prio_addr3 got=%h ok=%0d want=306", a, ok); end
        @(negedge clk);
        checks++; if (bus.core_start !== 2'b00) begin failures++; $display("FAIL prio_hold2 got=%b want=00", bus.core_start); end
        bus.core_done = 2'b11;
        @(negedge clk);
        bus.core_done = 2'b00;
        checks++; if (bus.core_start !== 2'b01 || bus.core_tile_addr !== 29'h306)
            begin failures++; $display("FAIL prio_both got=%b/%h want=01/306", bus.core_start, bus.core_tile_addr); end
        @(negedge clk);
        bus.core_done = 2'b01;
        @(negedge clk);
        bus.core_done = 2'b00;
        wait_frame_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL prio_frame_done got=0 want=1"); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [28:0] a;
        bit ok;
        start_frame(29'h1FFF_FFFE, 16'd2);
        serve_hdr(hdr(16'h7, 16'h8, 16'd1), a, ok);
        checks++; if (!ok || a !== 29'h1FFF_FFFE) begin failures++; $display("FAIL wrap_addr0 got=%h ok=%0d want=1ffffffe", a, ok); end
        @(negedge clk);
        serve_hdr(hdr(16'h9, 16'hA, 16'd0), a, ok);
        checks++; if (!ok || a !== 29'h4) begin failures++; $display("FAIL wrap_addr1 got=%h ok=%0d want=4", a, ok); end
        @(negedge clk);
        checks++; if (bus.core_start !== 2'b10 || bus.core_tile_addr !== 29'h4)
            begin failures++; $display("FAIL wrap_dispatch got=%b/%h want=10/4", bus.core_start, bus.core_tile_addr); end
        bus.core_done = 2'b11;
        @(negedge clk);
        bus.core_done = 2'b00;
        wait_frame_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_frame_done got=0 want=1"); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [28:0] a;
        bit ok;
        start_frame(29'h400, 16'd2);
        serve_hdr(hdr(16'hAA, 16'hBB, 16'd2), a, ok);
        @(negedge clk);
        checks++; if (bus.core_start !== 2'b01) begin failures++; $display("FAIL rmid_start0 got=%b want=01", bus.core_start); end
        wait_req(ok);
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack        = 1'b0;
        bus.rd_data_valid = 1'b1;
        bus.rd_data       = hdr(16'hCC, 16'hDD, 16'd4);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || bus.rd_req !== 1'b0 || bus.core_start !== 2'b00)
            begin failures++; $display("FAIL rmid_ctrl got=%b%b%b%b want=0000", busy, frame_done, bus.rd_req, bus.core_start); end
        checks++; if (bus.rd_addr !== 29'h0 || bus.core_tile_addr !== 29'h0 || bus.core_tile_px !== 16'h0 || bus.core_splat_count !== 16'h0)
            begin failures++; $display("FAIL rmid_buses got=%h/%h/%h/%h want=0", bus.rd_addr, bus.core_tile_addr, bus.core_tile_px, bus.core_splat_count); end
        checks++; if (bus.rd_burstcnt !== 8'd2) begin failures++; $display("FAIL rmid_burst got=%0d want=2", bus.rd_burstcnt); end
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_frame(29'h500, 16'd1);
        serve_hdr(hdr(16'h11, 16'h22, 16'd3), a, ok);
        checks++; if (!ok || a !== 29'h500) begin failures++; $display("FAIL rmid_addr got=%h ok=%0d want=500", a, ok); end
        @(negedge clk);
        checks++; if (bus.core_start !== 2'b01 || bus.core_splat_count !== 16'd3)
            begin failures++; $display("FAIL rmid_dispatch got=%b/%0d want=01/3", bus.core_start, bus.core_splat_count); end
        bus.core_done = 2'b01;
        @(negedge clk);
        bus.core_done = 2'b00;
        wait_frame_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rmid_frame_done got=0 want=1"); end
        @(negedge clk);
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        reset_n           = 1'b0;
        frame_start       = 1'b0;
        list_addr         = '0;
        tile_count        = '0;
        bus.rd_ack        = 1'b0;
        bus.rd_data       = '0;
        bus.rd_data_valid = 1'b0;
        bus.core_done     = '0;
        test_reset();
        test_zero_tiles();
        test_three_tiles();
        test_ack_stall();
        test_done_priority();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
